// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_pkg
// Description : Shared types and constants for the Fibonacci stream capture
//               block: control state encoding, default sizing and a
//               saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fib_pkg;

  // Control states of the capture block, explicitly two bits wide.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N     = 10;
  localparam int DEFAULT_DEPTH = 4;

  // Ceiling of the refused-term counter.
  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Increment an 8-bit counter, holding at DROP_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == DROP_MAX) ? value : value + 8'd1;
  endfunction

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fib_fifo
// Description : Small synchronous FIFO holding {index, term} words. Pointers
//               carry one extra wrap bit so full and empty are distinguished
//               without a separate counter. A synchronous flush empties it.
//               A push while full is discarded (no pass-through on pop).
//               The head word reads as zero whenever the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_fifo #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Same slot with differing wrap bits means every slot is occupied.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Flush overrides any transfer requested in the same cycle.
  assign do_push = push && !full  && !flush;
  assign do_pop  = pop  && !empty && !flush;

  // Pointer update; flush rewinds both pointers so the contents are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; stale entries are never visible because the head is gated.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule : fib_fifo
`default_nettype wire

// File: rtl/fib_stream_capture.sv
`default_nettype none
// ============================================================================
// Module      : fib_stream_capture
// Description : Accepts N Fibonacci terms under valid/ready, numbers each one,
//               checks it against the sum of the two previous accepted terms
//               (indices 0 and 1 are seeds), buffers {index, term} in a FIFO
//               for a downstream sink, then stops accepting and reports done
//               together with sticky mismatch / carry flags and a saturating
//               count of refused input cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_stream_capture
  import fib_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [$clog2(N)-1:0]  out_index,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  seq_err,
  output logic [$clog2(N)-1:0]  err_index,
  output logic                  wrap,
  output logic [7:0]            drop_cnt
);

  localparam int IDXW   = $clog2(N);
  localparam int FIFO_W = WIDTH + IDXW;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  state_t              state;
  logic [IDXW-1:0]     term_cnt;
  logic [WIDTH-1:0]    prev1;
  logic [WIDTH-1:0]    prev2;
  logic [WIDTH:0]      sum;
  logic                check_en;
  logic                mismatch;
  logic                accept;
  logic                refuse;
  logic                start_run;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFO_W-1:0]   fifo_head;

  // A start outside RUN arms a new run and flushes whatever is still queued.
  assign start_run = start && (state != RUN);

  // Room is judged on the current occupancy only; a same-cycle pop does not help.
  assign in_ready = (state == RUN) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign refuse   = (state == RUN) && in_valid && !in_ready;

  // Expected term kept one bit wider so the carry out of WIDTH is visible.
  assign sum      = {1'b0, prev1} + {1'b0, prev2};
  assign check_en = (term_cnt > IDX_ONE);
  assign mismatch = (sum[WIDTH-1:0] != in_data);

  // Control FSM with the checker, history and counters it governs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      term_cnt  <= '0;
      prev1     <= '0;
      prev2     <= '0;
      seq_err   <= 1'b0;
      err_index <= '0;
      wrap      <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_run) begin
            state     <= RUN;
            done      <= 1'b0;
            term_cnt  <= '0;
            prev1     <= '0;
            prev2     <= '0;
            seq_err   <= 1'b0;
            err_index <= '0;
            wrap      <= 1'b0;
            drop_cnt  <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            term_cnt <= term_cnt + IDX_ONE;
            prev2    <= prev1;
            prev1    <= in_data;
            if (check_en) begin
              // Only the first mismatch is recorded; later ones keep its index.
              if (mismatch && !seq_err) begin
                seq_err   <= 1'b1;
                err_index <= term_cnt;
              end
              if (sum[WIDTH]) wrap <= 1'b1;
            end
            if (term_cnt == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          if (refuse) drop_cnt <= sat_inc8(drop_cnt);
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  fib_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start_run),
    .push      (accept),
    .push_data ({term_cnt, in_data}),
    .pop       (out_ready),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The FIFO keeps draining in every state; only pushes depend on RUN.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[WIDTH-1:0];
  assign out_index = fifo_head[FIFO_W-1:WIDTH];

endmodule : fib_stream_capture
`default_nettype wire

// File: tb/tb_fib_stream_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_stream_capture
// Description : Directed self-checking bench for fib_stream_capture with
//               hand-computed expected values (WIDTH=32, N=10, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_stream_capture;

  localparam int WIDTH = 32;
  localparam int N     = 10;
  localparam int DEPTH = 4;
  localparam int IDXW  = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_index;
  logic             out_ready;
  logic             done;
  logic             seq_err;
  logic [IDXW-1:0]  err_index;
  logic             wrap;
  logic [7:0]       drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fib_seq [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
  logic [WIDTH-1:0] err_seq [10] = '{0, 1, 1, 2, 4, 7, 11, 18, 29, 47};
  logic [WIDTH-1:0] bp_seq  [6]  = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15};

  always #5 clk = ~clk;

  fib_stream_capture #(
    .WIDTH (WIDTH),
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_ready (out_ready),
    .done      (done),
    .seq_err   (seq_err),
    .err_index (err_index),
    .wrap      (wrap),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset values
    step();
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_index", out_index, 0);
    chk("rst_done",      done,      0);
    chk("rst_seq_err",   seq_err,   0);
    chk("rst_err_index", err_index, 0);
    chk("rst_wrap",      wrap,      0);
    chk("rst_drop_cnt",  drop_cnt,  0);
    step();
    rst_n = 1'b1;
    step();

    // in_valid in IDLE is ignored and not counted
    feed(32'h55);
    chk("idle_drop_cnt",  drop_cnt,  0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready",  in_ready,  0);

    // Clean run, sink always ready
    out_ready = 1'b1;
    pulse_start();
    chk("run1_in_ready", in_ready, 1);
    chk("run1_done0",    done,     0);
    for (int k = 0; k < 10; k++) begin
      feed(fib_seq[k]);
      chk("run1_out_valid", out_valid, 1);
      chk("run1_out_data",  out_data,  fib_seq[k]);
      chk("run1_out_index", out_index, k);
    end
    chk("run1_done",     done,     1);
    chk("run1_in_ready0", in_ready, 0);
    chk("run1_seq_err",  seq_err,  0);
    chk("run1_wrap",     wrap,     0);
    chk("run1_drop_cnt", drop_cnt, 0);
    step();
    chk("run1_drained", out_valid, 0);

    // Restart from DONE with a broken sequence
    pulse_start();
    chk("run2_done0",    done,     0);
    chk("run2_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) feed(err_seq[k]);
    chk("run2_seq_err_pre", seq_err, 0);
    feed(err_seq[4]);
    chk("run2_seq_err",   seq_err,   1);
    chk("run2_err_index", err_index, 4);
    feed(err_seq[5]);
    feed(err_seq[6]);
    chk("run2_err_index_keep", err_index, 4);
    for (int k = 7; k < 10; k++) feed(err_seq[k]);
    chk("run2_done",          done,      1);
    chk("run2_seq_err_final", seq_err,   1);
    chk("run2_err_idx_final", err_index, 4);
    chk("run2_drop_cnt",      drop_cnt,  0);

    // Restart clears flags and flushes; then back-pressure with sink stalled
    out_ready = 1'b0;
    pulse_start();
    chk("run3_seq_err_clr", seq_err,   0);
    chk("run3_err_idx_clr", err_index, 0);
    chk("run3_done_clr",    done,      0);
    chk("run3_flushed",     out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = bp_seq[i];
      step();
      chk("bp_in_ready", in_ready, (i < 3) ? 1 : 0);
      chk("bp_drop_cnt", drop_cnt, (i < 4) ? 0 : i - 3);
    end
    in_valid = 1'b0;
    chk("bp_drop_final", drop_cnt, 2);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_data",  out_data,  bp_seq[j]);
      chk("bp_drain_index", out_index, j);
      step();
    end
    chk("bp_drain_empty", out_valid, 0);
    chk("bp_in_ready_again", in_ready, 1);
    // 0x10,0x11 seeds; 0x12 != 0x21 so index 2 is the first mismatch
    chk("bp_seq_err",   seq_err,   1);
    chk("bp_err_index", err_index, 2);
    for (int k = 4; k < 10; k++) begin
      feed(fib_seq[k]);
      chk("run3_out_index", out_index, k);
      chk("run3_out_data",  out_data,  fib_seq[k]);
    end
    chk("run3_done",     done,     1);
    chk("run3_drop_cnt", drop_cnt, 2);

    // Carry out of WIDTH sets wrap without a mismatch
    pulse_start();
    chk("wrap_drop_clr", drop_cnt, 0);
    chk("wrap_err_clr",  seq_err,  0);
    feed(32'h8000_0000);
    feed(32'h8000_0000);
    chk("wrap_seed", wrap, 0);
    feed(32'h0000_0000);
    chk("wrap_set",     wrap,    1);
    chk("wrap_seq_err", seq_err, 0);
    feed(32'h8000_0000);
    feed(32'h8000_0000);
    chk("wrap_seq_err2", seq_err, 0);
    chk("wrap_sticky",   wrap,    1);
    chk("wrap_out_index", out_index, 4);

    // Asynchronous reset mid-run after 5 accepts
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  in_ready,  0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data",  out_data,  0);
    chk("arst_out_index", out_index, 0);
    chk("arst_done",      done,      0);
    chk("arst_seq_err",   seq_err,   0);
    chk("arst_err_index", err_index, 0);
    chk("arst_wrap",      wrap,      0);
    chk("arst_drop_cnt",  drop_cnt,  0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_idle_in_ready", in_ready, 0);
    pulse_start();
    feed(32'd5);
    chk("fresh_out_index0", out_index, 0);
    chk("fresh_out_data0",  out_data,  5);
    feed(32'd8);
    chk("fresh_out_index1", out_index, 1);
    chk("fresh_out_data1",  out_data,  8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fib_stream_capture
`default_nettype wire
